// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, op encodings and FSM states for the multiply controller
package mul_pkg;

    localparam int XLEN   = 64;
    localparam int PROD_W = 2 * XLEN;
    localparam int EXT_W  = XLEN + 2;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_result_sel.sv
// rtl/mul_result_sel.sv - picks and formats the architectural result from the full product
module mul_result_sel #(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] i_product,
    input  logic [1:0]        i_op,
    input  logic              i_word,
    output logic [XLEN-1:0]   o_result
);
    import mul_pkg::*;

    // Word ops sign-extend the low half-word; high ops take the upper product half
    always_comb begin
        o_result = i_product[XLEN-1:0];
        if (i_word) begin
            o_result = {{(XLEN/2){i_product[XLEN/2-1]}}, i_product[XLEN/2-1:0]};
        end else if (i_op != MUL_OP_MUL) begin
            o_result = i_product[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - sequencing controller for the Booth/Wallace multiplier datapath
module mul_ctrl #(
    parameter int XLEN        = 64,
    parameter int DP_LATENCY  = 2,
    parameter int ZERO_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_word,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    output logic [XLEN+1:0]   dp_a,
    output logic [XLEN+1:0]   dp_b,
    input  logic [2*XLEN-1:0] dp_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result
);
    import mul_pkg::*;

    localparam int CNT_W = (DP_LATENCY < 1) ? 1 : $clog2(DP_LATENCY + 1);

    mul_state_t       r_state;
    mul_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_word;
    logic [XLEN+1:0]  r_dp_a;
    logic [XLEN+1:0]  r_dp_b;
    logic [XLEN-1:0]  r_result;

    logic             w_accept;
    logic             w_bypass;
    logic             w_cnt_done;
    logic [1:0]       w_op;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [XLEN-1:0]  w_sel;

    // A held result may be replaced in the same cycle it is consumed
    assign in_ready   = !flush && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept   = in_valid && in_ready;
    assign w_bypass   = (ZERO_BYPASS != 0) && ((in_a == '0) || (in_b == '0));
    assign w_cnt_done = (r_cnt == CNT_W'(DP_LATENCY));
    assign w_op       = in_word ? MUL_OP_MUL : in_op;
    assign w_sign_a   = (w_op != MUL_OP_MULHU);
    assign w_sign_b   = (w_op == MUL_OP_MUL) || (w_op == MUL_OP_MULH);

    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign dp_a       = r_dp_a;
    assign dp_b       = r_dp_b;

    mul_result_sel #(.XLEN(XLEN)) u_sel (
        .i_product (dp_product),
        .i_op      (r_op),
        .i_word    (r_word),
        .o_result  (w_sel)
    );

    // Next-state: accept, wait out the datapath latency, hold until consumed; flush wins
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_bypass ? DONE : BUSY;
            end
            BUSY: begin
                if (w_cnt_done) w_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) w_next = w_bypass ? DONE : BUSY;
                    else          w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    // State register and latency counter; counter only runs while staying in BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= ((r_state == BUSY) && (w_next == BUSY)) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    // Operand latch on accept and result capture when the product is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= MUL_OP_MUL;
            r_word   <= 1'b0;
            r_dp_a   <= '0;
            r_dp_b   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_word <= in_word;
            if (w_bypass) begin
                r_result <= '0;
            end else begin
                r_dp_a <= {{2{w_sign_a & in_a[XLEN-1]}}, in_a};
                r_dp_b <= {{2{w_sign_b & in_b[XLEN-1]}}, in_b};
            end
        end else if ((r_state == BUSY) && w_cnt_done && !flush) begin
            r_result <= w_sel;
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - directed self-checking bench for mul_ctrl
module tb_mul_ctrl;
    import mul_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [1:0]   in_op;
    logic         in_word;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic         out_ready;

    logic         in_ready0, out_valid0, in_ready1, out_valid1;
    logic [65:0]  dp_a0, dp_b0, dp_a1, dp_b1;
    logic [127:0] dp_product0, dp_product1;
    logic [63:0]  out_result0, out_result1;

    logic signed [127:0] w_full0, w_full1;
    logic [127:0] r_p0a = '0, r_p0b = '0, r_p1a = '0, r_p1b = '0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.XLEN(64), .DP_LATENCY(2), .ZERO_BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b),
        .dp_a(dp_a0), .dp_b(dp_b0), .dp_product(dp_product0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0)
    );

    mul_ctrl #(.XLEN(64), .DP_LATENCY(2), .ZERO_BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b),
        .dp_a(dp_a1), .dp_b(dp_b1), .dp_product(dp_product1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1)
    );

    // Two-stage signed datapath model for each controller
    assign w_full0 = $signed(dp_a0) * $signed(dp_b0);
    assign w_full1 = $signed(dp_a1) * $signed(dp_b1);
    always @(posedge clk) begin
        r_p0a <= w_full0;
        r_p0b <= r_p0a;
        r_p1a <= w_full1;
        r_p1b <= r_p1a;
    end
    assign dp_product0 = r_p0b;
    assign dp_product1 = r_p1b;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single cycle; called just after a rising edge
    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        in_op    = op;
        in_word  = word;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        check("accept_ready", in_ready0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid, then step one edge
    task automatic wait_result(input string tag, input logic [63:0] exp, input int exp_lat);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid0) begin
                seen = 1'b1;
                n    = i;
            end else begin
                check({tag, "_busy_ready"}, in_ready0, 0);
                @(posedge clk);
                #1;
            end
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_result"}, out_result0, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat0, lat1;
        logic [63:0] res0, res1;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;

        @(negedge clk);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_result", out_result0, 0);
        check("rst_dp_a", dp_a0, 0);
        check("rst_dp_b", dp_b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready0, 1);
        @(posedge clk);
        #1;

        issue(MUL_OP_MUL, 1'b0, 64'd3, 64'd5);
        wait_result("mul_3x5", 64'd15, 4);

        issue(MUL_OP_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result("mulh_m1", 64'h0, 4);
        issue(MUL_OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result("mulhu_max", 64'hFFFF_FFFF_FFFF_FFFE, 4);
        issue(MUL_OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_result("mulhsu_m1x2", 64'hFFFF_FFFF_FFFF_FFFF, 4);

        issue(MUL_OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2);
        wait_result("mulw", 64'hFFFF_FFFF_FFFF_FFFE, 4);
        issue(MUL_OP_MULHU, 1'b1, 64'h7FFF_FFFF, 64'd2);
        wait_result("mulw_op11", 64'hFFFF_FFFF_FFFF_FFFE, 4);

        // Zero operand: bypass instance answers next cycle, the other runs full latency
        issue(MUL_OP_MUL, 1'b0, 64'd0, 64'h1234);
        lat0 = 0; lat1 = 0; res0 = '1; res1 = '1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid0 && lat0 == 0) begin lat0 = i; res0 = out_result0; end
            if (out_valid1 && lat1 == 0) begin lat1 = i; res1 = out_result1; end
            @(posedge clk);
            #1;
        end
        check("zero_byp_latency", lat0, 1);
        check("zero_byp_result", res0, 0);
        check("zero_byp_dp_a", dp_a0, 66'h7FFF_FFFF);
        check("zero_byp_dp_b", dp_b0, 66'd2);
        check("zero_nobyp_latency", lat1, 4);
        check("zero_nobyp_result", res1, 0);
        check("zero_nobyp_dp_b", dp_b1, 66'h1234);

        // Backpressure hold, then back-to-back accept on the consuming cycle
        out_ready = 1'b0;
        issue(MUL_OP_MUL, 1'b0, 64'd11, 64'd13);
        wait_result("bp_first", 64'd143, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid0, 1);
            check("bp_hold_result", out_result0, 64'd143);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(MUL_OP_MUL, 1'b0, 64'd7, 64'd6);
        wait_result("b2b_7x6", 64'd42, 4);

        // Flush in the second BUSY cycle with a competing request
        issue(MUL_OP_MUL, 1'b0, 64'd4, 64'd4);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = 64'd100;
        in_b     = 64'd100;
        @(negedge clk);
        check("flush_in_ready", in_ready0, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", in_ready0, 1);
        lat0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid0) lat0++;
        end
        check("flush_no_valid", lat0, 0);
        @(posedge clk);
        #1;
        issue(MUL_OP_MUL, 1'b0, 64'd8, 64'd9);
        wait_result("post_flush", 64'd72, 4);

        // Asynchronous reset in the middle of BUSY
        issue(MUL_OP_MUL, 1'b0, 64'd5, 64'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid0, 0);
        check("arst_out_result", out_result0, 0);
        check("arst_dp_a", dp_a0, 0);
        check("arst_dp_b", dp_b0, 0);
        check("arst_in_ready", in_ready0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(MUL_OP_MUL, 1'b0, 64'd5, 64'd5);
        wait_result("post_rst", 64'd25, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
